mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 44 ++++
 rtl/mem_access_align.sv | 63 ++++++
 rtl/mem_access.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: operation codes, writeback selects, FSM states.
// Also provides small decode helpers used by the stage and its alignment unit.
package mem_access_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Unassigned codes collapse to NONE so they pass straight through.
  function automatic mem_op_e decode_op(input logic [3:0] code);
    return (code > 4'd8) ? OP_NONE : mem_op_e'(code);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr[0];
      OP_LW, OP_SW:         return addr != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Byte-lane steering: store data replication and strobes, plus load byte/half
// extraction with sign or zero extension.
module mem_align
  import mem_access_pkg::*;
#(
  parameter int WORD = 32
) (
  input  mem_op_e         st_op,
  input  logic [1:0]      st_addr,
  input  logic [WORD-1:0] st_data,
  output logic [WORD-1:0] wdata,
  output logic [3:0]      wstrb,
  input  mem_op_e         ld_op,
  input  logic [1:0]      ld_addr,
  input  logic [WORD-1:0] rdata,
  output logic [WORD-1:0] ld_result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wdata = '0;
    wstrb = 4'b0000;
    case (st_op)
      OP_SB: begin
        wdata = WORD'({4{st_data[7:0]}});
        wstrb = 4'b0001 << st_addr;
      end
      OP_SH: begin
        wdata = WORD'({2{st_data[15:0]}});
        wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        wdata = st_data;
        wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = rdata[7:0];
    case (ld_addr)
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      2'd3:    ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half   = ld_addr[1] ? rdata[31:16] : rdata[15:0];
    ld_result = '0;
    // Stores and NONE fall through to zero.
    case (ld_op)
      OP_LB:   ld_result = {{(WORD-8){ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_result = {{(WORD-8){1'b0}}, ld_byte};
      OP_LH:   ld_result = {{(WORD-16){ld_half[15]}}, ld_half};
      OP_LHU:  ld_result = {{(WORD-16){1'b0}}, ld_half};
      OP_LW:   ld_result = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: accepts one op from execute, issues at most one
// data-memory request, and presents the result to writeback with a valid/ready handshake.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int WORD     = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          mem_op,
  input  logic [WORD-1:0]     alu_out,
  input  logic [WORD-1:0]     store_data,
  input  logic [WORD-1:0]     pc_i,
  input  logic [4:0]          rd_i,
  input  logic [1:0]          wb_sel_i,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [WORD-1:0]     dmem_wdata,
  output logic [3:0]          dmem_wstrb,
  input  logic                dmem_ack,
  input  logic [WORD-1:0]     dmem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD-1:0]     alu_result,
  output logic [WORD-1:0]     dmem_result,
  output logic [WORD-1:0]     pc_o,
  output logic [4:0]          rd_o,
  output logic [1:0]          wb_sel_o,
  output logic                misalign_o
);

  state_e                state, state_nxt;
  mem_op_e               op_in, op_q;
  logic [1:0]            addr_lo_q;
  logic [ADDR_LEN-1:0]   addr_in;
  logic                  accept, mis_in, go_mem;
  logic [WORD-1:0]       st_wdata, ld_result;
  logic [3:0]            st_wstrb;

  assign op_in    = decode_op(mem_op);
  assign addr_in  = alu_out[ADDR_LEN-1:0];
  assign mis_in   = is_misaligned(op_in, alu_out[1:0]);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // Misaligned accesses never reach memory; they retire like NONE.
  assign go_mem   = accept && (op_in != OP_NONE) && !mis_in;

  mem_align #(.WORD(WORD)) u_align (
    .st_op    (op_in),
    .st_addr  (alu_out[1:0]),
    .st_data  (store_data),
    .wdata    (st_wdata),
    .wstrb    (st_wstrb),
    .ld_op    (op_q),
    .ld_addr  (addr_lo_q),
    .rdata    (dmem_rdata),
    .ld_result(ld_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_mem)    state_nxt = ACCESS;
      ACCESS:  if (dmem_ack)  state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_wstrb  <= 4'b0000;
      alu_result  <= '0;
      dmem_result <= '0;
      pc_o        <= '0;
      rd_o        <= '0;
      wb_sel_o    <= '0;
      misalign_o  <= 1'b0;
      op_q        <= OP_NONE;
      addr_lo_q   <= 2'b00;
    end else if (accept) begin
      alu_result  <= alu_out;
      pc_o        <= pc_i;
      rd_o        <= rd_i;
      wb_sel_o    <= wb_sel_i;
      op_q        <= op_in;
      addr_lo_q   <= alu_out[1:0];
      misalign_o  <= mis_in;
      dmem_result <= '0;
      out_valid   <= !go_mem;
      if (go_mem) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_store(op_in);
        dmem_addr  <= {addr_in[ADDR_LEN-1:2], 2'b00};
        dmem_wdata <= st_wdata;
        dmem_wstrb <= st_wstrb;
      end
    end else if (state == ACCESS && dmem_ack) begin
      dmem_req    <= 1'b0;
      dmem_result <= ld_result;
      out_valid   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
